sram_like_arbiter: RTL

- Shares one sram-like memory port between the instruction-fetch master and the data master (the port behind data_sram_data_ok in the memory stage).
- Grants one address phase per cycle and locks the grant until addr_ok.
- Records the owner of every accepted request in an in-order tag FIFO, so each data_ok/rdata returns to its owner.
- Data requests have priority; a starvation counter guarantees instruction-fetch progress.

---
 rtl/sram_like_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like port arbiter: data-priority grant with an inst starvation guard,
// address-phase lock until addr_ok, and an in-order owner tag FIFO for routing responses.
module sram_like_arbiter #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          resetn,

  input  logic                          inst_req,
  input  logic                          inst_wr,
  input  logic [1:0]                    inst_size,
  input  logic [31:0]                   inst_addr,
  input  logic [31:0]                   inst_wdata,
  output logic                          inst_addr_ok,
  output logic                          inst_data_ok,
  output logic [31:0]                   inst_rdata,

  input  logic                          data_req,
  input  logic                          data_wr,
  input  logic [1:0]                    data_size,
  input  logic [31:0]                   data_addr,
  input  logic [31:0]                   data_wdata,
  output logic                          data_addr_ok,
  output logic                          data_data_ok,
  output logic [31:0]                   data_rdata,

  output logic                          mem_req,
  output logic                          mem_wr,
  output logic [1:0]                    mem_size,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_addr_ok,
  input  logic                          mem_data_ok,
  input  logic [31:0]                   mem_rdata,

  output logic [$clog2(OUTSTANDING):0]  pend_cnt,
  output logic                          proto_err
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(OUTSTANDING);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic             lock_valid_q, lock_valid_d;
  logic             lock_id_q, lock_id_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             proto_err_q, proto_err_d;
  logic             tag_q [OUTSTANDING];

  logic fifo_full;
  logic grant_valid;
  logic grant_id;
  logic sel_inst;
  logic req_int;
  logic accept;
  logic pop;
  logic head_id;

  assign fifo_full = (count_q == CNT_FULL);

  // A held lock overrides priority so the presented address never changes mid-handshake.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_DATA;
    if (!fifo_full) begin
      if (lock_valid_q) begin
        grant_valid = 1'b1;
        grant_id    = lock_id_q;
      end else if (inst_req && (!data_req || starve_q == STARVE_MAX)) begin
        grant_valid = 1'b1;
        grant_id    = ID_INST;
      end else if (data_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_DATA;
      end else if (inst_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_INST;
      end
    end
  end

  assign sel_inst = grant_valid && (grant_id == ID_INST);
  assign req_int  = resetn && grant_valid && (sel_inst ? inst_req : data_req);
  assign accept   = req_int && mem_addr_ok;

  assign mem_req   = req_int;
  assign mem_wr    = sel_inst ? inst_wr    : data_wr;
  assign mem_size  = sel_inst ? inst_size  : data_size;
  assign mem_addr  = sel_inst ? inst_addr  : data_addr;
  assign mem_wdata = sel_inst ? inst_wdata : data_wdata;

  assign inst_addr_ok = accept && (grant_id == ID_INST);
  assign data_addr_ok = accept && (grant_id == ID_DATA);

  assign pop     = resetn && mem_data_ok && (count_q != '0);
  assign head_id = tag_q[rd_ptr_q];

  assign inst_data_ok = pop && (head_id == ID_INST);
  assign data_data_ok = pop && (head_id == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign pend_cnt  = count_q;
  assign proto_err = proto_err_q;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    starve_d     = starve_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    proto_err_d  = proto_err_q;

    if (accept) begin
      lock_valid_d = 1'b0;
    end else if (req_int) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant_id;
    end

    // Starvation count only tracks data wins that happen while inst is actually waiting.
    if (!inst_req) begin
      starve_d = '0;
    end else if (accept && grant_id == ID_INST) begin
      starve_d = '0;
    end else if (accept && grant_id == ID_DATA && starve_q != STARVE_MAX) begin
      starve_d = starve_q + SC_W'(1);
    end

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (mem_data_ok && count_q == '0) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_INST;
      starve_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      starve_q     <= starve_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      proto_err_q  <= proto_err_d;
    end
  end

  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_tag
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        tag_q[gi] <= ID_INST;
      end else if (accept && wr_ptr_q == PTR_W'(gi)) begin
        tag_q[gi] <= grant_id;
      end
    end
  end

endmodule
